// File: rtl/calc_cmd_scheduler.sv
// Round-robin front end for Calculator_Top: accepts whole calculations from two
// requesters and serialises each one into the keypad-style cmd word stream.
module calc_cmd_scheduler #(
    parameter int NDIG = 4,
    parameter int HOLD = 1,
    parameter int GAP  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid0,
    input  logic              valid1,
    output logic              ready0,
    output logic              ready1,
    input  logic [4*NDIG-1:0] a0,
    input  logic [4*NDIG-1:0] a1,
    input  logic [4*NDIG-1:0] b0,
    input  logic [4*NDIG-1:0] b1,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    output logic [3:0]        cmd,
    output logic              busy,
    output logic              grant_id,
    output logic              err
);

    localparam int DW = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [HW-1:0] HOLD_L = HW'(HOLD);
    localparam logic [GW-1:0] GAP_L  = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_OP, SEND_B, SEND_EQ, GAP_ST} state_t;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    op;
    } req_t;

    // Index of the most significant non-zero digit; 0 for an all-zero operand.
    function automatic logic [IW-1:0] lead(input logic [DW-1:0] x);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++)
            if (x[4*i +: 4] != 4'd0) r = IW'(i);
        return r;
    endfunction

    function automatic logic is_bcd(input logic [DW-1:0] x);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIG; i++)
            if (x[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    state_t        st, st_n;
    req_t          rq, rq_n, in_sel;
    logic [IW-1:0] idx, idx_n;
    logic [HW-1:0] hc, hc_n;
    logic [GW-1:0] gc, gc_n;
    logic          ptr, ptr_n, sel, take;
    logic          grant_n, err_n;
    logic [3:0]    cmd_n;

    assign sel    = (valid0 & valid1) ? ptr : valid1;
    assign take   = (st == IDLE) & (valid0 | valid1);
    assign ready0 = ~reset & take & ~sel;
    assign ready1 = ~reset & take & sel;

    always_comb begin
        in_sel.a  = sel ? a1 : a0;
        in_sel.b  = sel ? b1 : b0;
        in_sel.op = sel ? op1 : op0;
    end

    // State/counters describe the word that will be on cmd next cycle, so
    // cmd is registered straight from the next-state view.
    always_comb begin
        st_n    = st;
        rq_n    = rq;
        idx_n   = idx;
        hc_n    = hc;
        gc_n    = gc;
        ptr_n   = ptr;
        grant_n = grant_id;
        err_n   = 1'b0;
        case (st)
            IDLE: begin
                if (take) begin
                    rq_n    = in_sel;
                    ptr_n   = ~sel;
                    grant_n = sel;
                    if (is_bcd(in_sel.a) && is_bcd(in_sel.b)) begin
                        st_n  = SEND_A;
                        idx_n = lead(in_sel.a);
                        hc_n  = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SEND_A, SEND_OP, SEND_B, SEND_EQ: begin
                if (hc != HOLD_L) begin
                    hc_n = hc + 1'b1;
                end else begin
                    // End of the separating NOP: move to the next word.
                    hc_n = '0;
                    case (st)
                        SEND_A: begin
                            if (idx == '0) st_n = SEND_OP;
                            else           idx_n = idx - 1'b1;
                        end
                        SEND_OP: begin
                            st_n  = SEND_B;
                            idx_n = lead(rq.b);
                        end
                        SEND_B: begin
                            if (idx == '0) st_n = SEND_EQ;
                            else           idx_n = idx - 1'b1;
                        end
                        default: begin
                            gc_n = '0;
                            st_n = (GAP == 0) ? IDLE : GAP_ST;
                        end
                    endcase
                end
            end
            GAP_ST: begin
                if (gc == GAP_L) st_n = IDLE;
                else             gc_n = gc + 1'b1;
            end
            default: st_n = IDLE;
        endcase

        cmd_n = 4'hF;
        if (hc_n != HOLD_L) begin
            case (st_n)
                SEND_A:  cmd_n = rq_n.a[{idx_n, 2'b00} +: 4];
                SEND_OP: cmd_n = 4'hA + {2'b00, rq_n.op};
                SEND_B:  cmd_n = rq_n.b[{idx_n, 2'b00} +: 4];
                SEND_EQ: cmd_n = 4'hE;
                default: cmd_n = 4'hF;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            rq       <= '0;
            idx      <= '0;
            hc       <= '0;
            gc       <= '0;
            ptr      <= 1'b0;
            grant_id <= 1'b0;
            err      <= 1'b0;
            cmd      <= 4'hF;
            busy     <= 1'b0;
        end else begin
            st       <= st_n;
            rq       <= rq_n;
            idx      <= idx_n;
            hc       <= hc_n;
            gc       <= gc_n;
            ptr      <= ptr_n;
            grant_id <= grant_n;
            err      <= err_n;
            cmd      <= cmd_n;
            busy     <= (st_n != IDLE);
        end
    end

endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// Directed bench for calc_cmd_scheduler: expected cmd streams are built by a
// small model into a queue at acceptance and popped cycle by cycle.
module tb_calc_cmd_scheduler;

    localparam int NDIG = 4;
    localparam int HOLD = 1;
    localparam int GAP  = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid0, valid1;
    logic        ready0, ready1;
    logic [15:0] a0, a1, b0, b1;
    logic [1:0]  op0, op1;
    logic [3:0]  cmd;
    logic        busy, grant_id, err;

    int n_pass  = 0;
    int n_total = 0;
    logic [3:0] sb[$];

    calc_cmd_scheduler #(.NDIG(NDIG), .HOLD(HOLD), .GAP(GAP)) dut (
        .clock(clock), .reset(reset),
        .valid0(valid0), .valid1(valid1), .ready0(ready0), .ready1(ready1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .op0(op0), .op1(op1),
        .cmd(cmd), .busy(busy), .grant_id(grant_id), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [3:0] w);
        for (int i = 0; i < HOLD; i++) sb.push_back(w);
        sb.push_back(4'hF);
    endtask

    task automatic push_operand(input logic [15:0] x);
        int ld;
        ld = 0;
        for (int i = NDIG - 1; i >= 0; i--)
            if (ld == 0 && x[4*i +: 4] != 4'd0) ld = i;
        for (int i = ld; i >= 0; i--) push_word(x[4*i +: 4]);
    endtask

    task automatic push_req(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        push_operand(a);
        push_word(4'hA + {2'b00, op});
        push_operand(b);
        push_word(4'hE);
        for (int i = 0; i < GAP; i++) sb.push_back(4'hF);
    endtask

    // Called at posedge+1 in an IDLE cycle with the request(s) already driven.
    task automatic accept(input logic gid);
        chk("ready0_grant", ready0, !gid);
        chk("ready1_grant", ready1, gid);
        @(posedge clock); #1;
        if (gid) push_req(a1, b1, op1);
        else     push_req(a0, b0, op0);
        chk("grant_id", grant_id, gid);
        chk("err_ok", err, 1'b0);
    endtask

    task automatic serve_n(input int n);
        logic [3:0] w;
        for (int i = 0; i < n; i++) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1'b1, 1'b0);
                return;
            end
            w = sb.pop_front();
            chk("cmd", cmd, w);
            chk("busy", busy, 1'b1);
            chk("ready0_busy", ready0, 1'b0);
            chk("ready1_busy", ready1, 1'b0);
            @(posedge clock); #1;
        end
    endtask

    task automatic serve();
        serve_n(sb.size());
        chk("busy_end", busy, 1'b0);
        chk("cmd_end", cmd, 4'hF);
    endtask

    initial begin
        reset = 1'b1;
        valid0 = 0; valid1 = 0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = '0; op1 = '0;
        #12;
        chk("rst_cmd", cmd, 4'hF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_gid", grant_id, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_ready0", ready0, 1'b0);
        chk("idle_ready1", ready1, 1'b0);

        // Single request, leading zeros suppressed.
        valid0 = 1; a0 = 16'h0012; b0 = 16'h0003; op0 = 2'b00;
        #1;
        accept(1'b0);
        valid0 = 0;
        chk("sb_len12", 16'(sb.size()), 16'd12);
        serve();

        // Zero operands on requester 1.
        valid1 = 1; a1 = 16'h0000; b1 = 16'h0000; op1 = 2'b01;
        #1;
        accept(1'b1);
        valid1 = 0;
        serve();

        // Contention from reset: both held, grants alternate 0,1,0,1.
        reset = 1'b1;
        a0 = 16'h0705; b0 = 16'h0011; op0 = 2'b10;
        a1 = 16'h9000; b1 = 16'h0008; op1 = 2'b11;
        valid0 = 1; valid1 = 1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            accept(k[0]);
            serve();
        end
        valid0 = 0; valid1 = 0;
        @(posedge clock); #1;

        // Invalid BCD: accepted, err one cycle later, no stream.
        valid0 = 1; a0 = 16'h00A1; b0 = 16'h0005; op0 = 2'b00;
        #1;
        chk("bad_ready0", ready0, 1'b1);
        @(posedge clock); #1;
        chk("bad_err", err, 1'b1);
        chk("bad_busy", busy, 1'b0);
        chk("bad_cmd", cmd, 4'hF);
        chk("bad_gid", grant_id, 1'b0);
        valid0 = 0;
        valid1 = 1; a1 = 16'h0042; b1 = 16'h0007; op1 = 2'b10;
        #1;
        accept(1'b1);
        valid1 = 0;
        serve();

        // Mid-sequence reset during SEND_B.
        valid1 = 1; a1 = 16'h1234; b1 = 16'h0567; op1 = 2'b01;
        #1;
        accept(1'b1);
        valid1 = 0;
        serve_n(11);
        #3;
        a0 = 16'h0081; b0 = 16'h0020; op0 = 2'b00;
        valid0 = 1; valid1 = 1;
        reset = 1'b1;
        #1;
        chk("mid_cmd", cmd, 4'hF);
        chk("mid_busy", busy, 1'b0);
        chk("mid_err", err, 1'b0);
        chk("mid_gid", grant_id, 1'b0);
        chk("mid_ready0", ready0, 1'b0);
        chk("mid_ready1", ready1, 1'b0);
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        accept(1'b0);
        valid0 = 0;
        serve();
        accept(1'b1);
        valid1 = 0;
        serve();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/calc_cmd_scheduler.md
# calc_cmd_scheduler

Front-end controller for `Calculator_Top`. Two independent requesters each submit a complete calculation: two BCD operands and an operator. The block arbitrates between them round-robin and serialises each accepted request into the keypad-style `cmd` word stream the calculator consumes: digits of A, the operator, digits of B, then equals. It owns the `cmd[3:0]` input of the calculator, so the calculator is shared without command interleaving.

## Interface
- `NDIG`, default 4: BCD digits per operand.
- `HOLD`, default 1: cycles each cmd word is driven before the separating NOP.
- `GAP`, default 2: NOP cycles after equals before the next grant.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `valid0` / `valid1`, in, 1: request present.
- `ready0` / `ready1`, out, 1: request accepted this cycle.
- `a0` / `a1`, in, 4*NDIG: operand A, packed BCD, MS digit in the top nibble.
- `b0` / `b1`, in, 4*NDIG: operand B, packed BCD.
- `op0` / `op1`, in, 2: operator code. 00 add, 01 sub, 10 mul, 11 div.
- `cmd`, out, 4: command word to the calculator.
- `busy`, out, 1: a request is being serialised, including GAP.
- `grant_id`, out, 1: requester of the current or last accepted request.
- `err`, out, 1: one-cycle pulse when an accepted request contained a non-BCD nibble.

## Operation
- Cmd encoding:
  - 0000–1001: digit 0–9.
  - Operators: add 1010, sub 1011, mul 1100, div 1101.
  - 1110: equals.
  - 1111: NOP (idle value).
- States: IDLE, SEND_A, SEND_OP, SEND_B, SEND_EQ, GAP.
- **IDLE:** if any valid is high, select one using the round-robin pointer.
  - `ready_sel` goes high combinationally in that cycle.
  - a, b and op are latched on that edge.
  - `grant_id` is updated on that edge.
  - The pointer moves to the other requester.
  - The requester must hold its valid and data stable until ready is high.
- **Arbitration:**
  - Only one valid high: that requester is granted regardless of the pointer.
  - Both valid high: the requester named by the pointer is granted.
  - The pointer resets to requester 0.
- **Operand emission:**
  - Digits are emitted MS-first with leading zeros suppressed.
  - An all-zero operand emits a single 0000.
- **Word framing:** every word is driven for HOLD cycles, followed by 1 NOP cycle, so repeated digits stay distinct.
- **Flow:** SEND_A → SEND_OP → SEND_B → SEND_EQ → GAP. GAP holds NOP for GAP cycles, then returns to IDLE.
- **Invalid BCD:** if any nibble of the latched a or b is greater than 9, the request is still accepted (ready pulses).
  - `err` pulses in the cycle after acceptance.
  - No cmd words are emitted, and the state returns directly to IDLE.
  - `busy` stays 0.
- `busy` = 1 in every non-IDLE state.
- Valid inputs are ignored while busy; ready0 and ready1 are 0 outside IDLE.
- **Reset (asynchronous, any time, including mid-sequence):**
  - Outputs go immediately to: `cmd` = 1111, `busy` = 0, `ready*` = 0, `err` = 0, `grant_id` = 0.
  - Internal: state = IDLE, pointer = 0.
  - The aborted request is discarded and not retried.

## Timing
- Acceptance edge E0. The first digit of A is on `cmd` in the cycle after E0. No extra latency.
- Total busy cycles = (nA + nB + 2)·(HOLD + 1) + GAP, where nA and nB are the emitted digit counts.
- Earliest next acceptance is in the first IDLE cycle after GAP. Back-to-back grants are therefore separated by exactly GAP NOP cycles after the equals NOP.
- `cmd`, `busy`, `grant_id` and `err` are registered outputs. `ready*` is combinational from state, pointer and valid.

## Test plan
- **Reset:** assert reset mid-cycle → cmd = 1111, busy = 0, ready0 = ready1 = 0, err = 0 without waiting for a clock edge.
- **Single request:** req0 with a = 0x0012, b = 0x0003, op = 00 (HOLD = 1, GAP = 2).
  - Required cmd: 0001, 1111, 0010, 1111, 1010, 1111, 0011, 1111, 1110, 1111, 1111, 1111.
  - busy high for exactly 12 cycles, grant_id = 0.
- **Zero operands:** req1 with a = 0, b = 0, op = 01.
  - Required cmd: 0000, 1111, 1011, 1111, 0000, 1111, 1110, 1111, then GAP NOPs.
  - grant_id = 1.
- **Contention:** valid0 and valid1 both held high from reset with distinct operands.
  - req0 is served first; req1 is accepted in the first IDLE cycle after GAP.
  - If both are re-asserted, req0 is served next; the grant order is 0, 1, 0, 1.
- **Invalid BCD:** req0 with a = 0x00A1.
  - ready0 pulses; err pulses one cycle later.
  - cmd stays 1111 and busy stays 0.
  - A following valid req1 is accepted on the next IDLE cycle.
- **Mid-sequence reset:** assert reset during SEND_B.
  - cmd = 1111 and busy = 0 immediately.
  - After release, with both requesters valid, req0 is granted first.
